panel_writer: RTL and testbench

- Write side of the Score 4 game panel.
- Accepts a one-hot column play from the input/controller logic and finds the lowest free cell in that column.
- Animates the piece falling row by row, then commits it to the registered 7x6 panel and hands the turn to the other player.
- Owns the authoritative panel state that the display, free-row lookup and win-detection logic read.

---
 rtl/score4_pkg.sv | 27 ++
 rtl/drop_target.sv | 22 ++
 rtl/panel_writer.sv | 151 +++++++++++++++
 tb/tb_panel_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score4_pkg.sv
// Shared types for the Score 4 panel: board geometry, cell colours and writer FSM states.
package score4_pkg;

    localparam int NCOLS = 7;
    localparam int NROWS = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef cell_t [NROWS-1:0]            column_t;
    typedef cell_t [NCOLS-1:0][NROWS-1:0] panel_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FALL,
        COMMIT
    } wr_state_t;

    function automatic cell_t other_player(input cell_t c);
        return (c == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/drop_target.sv
// Lowest free cell of one column (row 5 = bottom); purely combinational, no flow control.
module drop_target
    import score4_pkg::*;
(
    input  column_t    cells,
    output logic [2:0] target,
    output logic       full
);

    // Later (higher-index) empty rows override earlier ones, leaving the lowest free cell.
    always_comb begin
        target = 3'd0;
        full   = 1'b1;
        for (int r = 0; r < NROWS; r++) begin
            if (cells[r] == EMPTY) begin
                target = 3'(r);
                full   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/panel_writer.sv
// Score 4 panel write side: accepts a column play, animates the drop, commits and swaps turn.
// move_done (target+1)*DROP_TICKS+2 edges after acceptance; plays are only taken while ready.
module panel_writer
    import score4_pkg::*;
#(
    parameter int DROP_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    input  logic [NCOLS-1:0] play,
    input  logic             play_valid,
    output logic             ready,
    output logic [1:0]       turn,
    output panel_t           panel,
    output panel_t           disp_panel,
    output logic             move_done,
    output logic             move_invalid
);

    localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;

    wr_state_t        state_q, state_d;
    logic [NCOLS-1:0] col_q;
    logic [2:0]       col_idx_q, sel_idx;
    logic [2:0]       target_q, tgt;
    logic [2:0]       cur_row_q;
    logic [TW-1:0]    tick_q;
    panel_t           panel_q, disp_q, disp_d;
    cell_t            turn_q;
    logic             done_q, inval_q;
    logic             col_full, col_ok, tick_last;
    logic             load_col, start_fall, step_row, commit, reject;

    always_comb begin
        sel_idx = 3'd0;
        for (int c = 0; c < NCOLS; c++) begin
            if (col_q[c]) sel_idx = 3'(c);
        end
    end

    drop_target u_drop_target (
        .cells  (panel_q[sel_idx]),
        .target (tgt),
        .full   (col_full)
    );

    assign col_ok    = $onehot(col_q) && !col_full;
    assign tick_last = (tick_q == TW'(DROP_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // new_game bypasses the case entirely, so no strobe can fire in its cycle.
    always_comb begin
        state_d    = state_q;
        load_col   = 1'b0;
        start_fall = 1'b0;
        step_row   = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        if (new_game) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (play_valid) begin
                        load_col = 1'b1;
                        state_d  = CHECK;
                    end
                end
                CHECK: begin
                    if (col_ok) begin
                        start_fall = 1'b1;
                        state_d    = FALL;
                    end else begin
                        reject  = 1'b1;
                        state_d = IDLE;
                    end
                end
                FALL: begin
                    if (tick_last) begin
                        if (cur_row_q == target_q) state_d  = COMMIT;
                        else                       step_row = 1'b1;
                    end
                end
                COMMIT: begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        disp_d = panel_q;
        if (state_q == FALL) disp_d[col_idx_q][cur_row_q] = turn_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            col_idx_q <= 3'd0;
            target_q  <= 3'd0;
            cur_row_q <= 3'd0;
            tick_q    <= '0;
            panel_q   <= panel_t'('0);
            disp_q    <= panel_t'('0);
            turn_q    <= P1;
            done_q    <= 1'b0;
            inval_q   <= 1'b0;
        end else begin
            done_q  <= commit;
            inval_q <= reject;
            disp_q  <= disp_d;
            if (new_game) begin
                panel_q   <= panel_t'('0);
                turn_q    <= P1;
                tick_q    <= '0;
                cur_row_q <= 3'd0;
            end else begin
                if (load_col) col_q <= play;
                if (start_fall) begin
                    col_idx_q <= sel_idx;
                    target_q  <= tgt;
                    cur_row_q <= 3'd0;
                    tick_q    <= '0;
                end
                if (state_q == FALL) begin
                    tick_q <= tick_last ? '0 : tick_q + 1'b1;
                    if (step_row) cur_row_q <= cur_row_q + 3'd1;
                end
                if (commit) begin
                    panel_q[col_idx_q][target_q] <= turn_q;
                    turn_q                       <= other_player(turn_q);
                end
            end
        end
    end

    assign ready        = (state_q == IDLE);
    assign turn         = turn_q;
    assign panel        = panel_q;
    assign disp_panel   = disp_q;
    assign move_done    = done_q;
    assign move_invalid = inval_q;

endmodule

// File: tb/tb_panel_writer.sv
// Scoreboard bench for panel_writer: a column-count board model predicts each move's outcome.
module tb_panel_writer;

    localparam int D = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   new_game = 1'b0;
    logic [6:0]             play = 7'd0;
    logic                   play_valid = 1'b0;
    logic                   ready;
    logic [1:0]             turn;
    logic [6:0][5:0][1:0]   panel;
    logic [6:0][5:0][1:0]   disp_panel;
    logic                   move_done;
    logic                   move_invalid;

    panel_writer #(.DROP_TICKS(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .play         (play),
        .play_valid   (play_valid),
        .ready        (ready),
        .turn         (turn),
        .panel        (panel),
        .disp_panel   (disp_panel),
        .move_done    (move_done),
        .move_invalid (move_invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp = 0;
    int bad = 0;

    typedef struct {
        bit          inv;
        int          due;
        logic [83:0] pan;
        logic [1:0]  trn;
    } exp_t;
    exp_t sbq[$];

    // Reference model: pieces per column plus a colour grid.
    int         cnt[7];
    logic [1:0] mp[7][6];
    logic [1:0] mturn;

    bit         fall_on = 1'b0;
    int         fall_col, fall_row, fall_acc;
    logic [1:0] fall_clr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [83:0] mpack();
        logic [83:0] v;
        v = '0;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                v[(c*6+r)*2 +: 2] = mp[c][r];
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 7; c++) begin
            cnt[c] = 0;
            for (int r = 0; r < 6; r++) mp[c][r] = 2'b00;
        end
        mturn = 2'b01;
    endtask

    // Pulse monitor: every done/invalid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (move_done || move_invalid) begin
                if (sbq.size() == 0) begin
                    cmp++;
                    bad++;
                    $display("FAIL unexpected_pulse: done=%0b invalid=%0b with nothing pending (cycle %0d)",
                             move_done, move_invalid, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_kind", {move_done, move_invalid}, e.inv ? 2'b01 : 2'b10);
                    chk("pulse_cycle", cyc, e.due);
                    chk("panel_after_move", panel, e.pan);
                    chk("turn_after_move", turn, e.trn);
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
                e = sbq.pop_front();
                cmp++;
                bad++;
                $display("FAIL missing_pulse: no pulse observed, expected at cycle %0d (now %0d)", e.due, cyc);
            end
        end
    end

    // Falling piece overlay: one row per D cycles, lagging the FSM by one register.
    always @(negedge clk) begin
        int k;
        if (fall_on && !rst) begin
            k = cyc - fall_acc;
            if (k >= 2 && (k - 2) < (fall_row + 1) * D)
                chk("disp_falling_cell", disp_panel[fall_col][(k-2)/D], fall_clr);
        end
    end

    task automatic do_play(input logic [6:0] p);
        int   acc, w, c, row;
        bit   valid;
        exp_t e;
        @(negedge clk);
        w = 0;
        while (!ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        play       = p;
        play_valid = 1'b1;
        @(negedge clk);
        play_valid = 1'b0;
        acc        = cyc;
        chk("ready_low_after_accept", ready, 1'b0);

        c = 0;
        for (int i = 0; i < 7; i++) if (p[i]) c = i;
        valid = $onehot(p) && (cnt[c] < 6);
        if (valid) begin
            row      = 5 - cnt[c];
            fall_col = c;
            fall_row = row;
            fall_clr = mturn;
            fall_acc = acc;
            fall_on  = 1'b1;
            cnt[c]++;
            mp[c][row] = mturn;
            mturn      = (mturn == 2'b01) ? 2'b10 : 2'b01;
            e.inv = 1'b0;
            e.due = acc + (row + 1) * D + 2;
        end else begin
            e.inv = 1'b1;
            e.due = acc + 1;
        end
        e.pan = mpack();
        e.trn = mturn;
        sbq.push_back(e);

        w = 0;
        while (sbq.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            cmp++;
            bad++;
            $display("FAIL response_timeout: queue depth %0d expected 0", sbq.size());
            sbq.delete();
        end
        fall_on = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] p;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 1'b1);
        chk("reset_turn", turn, 2'b01);
        chk("reset_panel", panel, 84'd0);
        chk("reset_disp", disp_panel, 84'd0);
        chk("reset_done", move_done, 1'b0);
        chk("reset_invalid", move_invalid, 1'b0);
        rst = 1'b0;

        // Two stacked plays in column 0.
        do_play(7'b0000001);
        do_play(7'b0000001);

        // Fill column 3, then overflow it.
        for (int i = 0; i < 7; i++) do_play(7'b0001000);

        // Malformed column selects.
        do_play(7'b0000000);
        do_play(7'b0000011);

        // Random plays, mostly one-hot, some arbitrary patterns.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 4) == 0) p = 7'($urandom_range(0, 127));
            else                           p = 7'(1 << $urandom_range(0, 6));
            do_play(p);
        end

        // new_game mid-fall, with a simultaneous play request that must be dropped.
        @(negedge clk);
        play       = 7'b0100000;
        play_valid = 1'b1;
        @(negedge clk);
        play_valid = 1'b0;
        repeat (6) @(negedge clk);
        new_game   = 1'b1;
        play       = 7'b0000100;
        play_valid = 1'b1;
        @(negedge clk);
        new_game   = 1'b0;
        play_valid = 1'b0;
        model_clear();
        chk("newgame_panel", panel, 84'd0);
        chk("newgame_turn", turn, 2'b01);
        chk("newgame_ready", ready, 1'b1);
        @(negedge clk);
        chk("newgame_play_dropped", ready, 1'b1);
        repeat (40) @(negedge clk);

        // Commit one piece, then hit async reset part way through the next drop.
        do_play(7'b1000000);
        @(negedge clk);
        play       = 7'b0000010;
        play_valid = 1'b1;
        @(negedge clk);
        play_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", ready, 1'b1);
        chk("arst_turn", turn, 2'b01);
        chk("arst_panel", panel, 84'd0);
        chk("arst_disp", disp_panel, 84'd0);
        chk("arst_done", move_done, 1'b0);
        chk("arst_invalid", move_invalid, 1'b0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        do_play(7'b0000010);
        do_play(7'b0000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
